// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: datapath widths, NOP word, PC step, FSM states
// and the IF/ID register layout.
package if_stage_pkg;
  localparam int          DATA_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  pc4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc4: '0, instr: NOP_WORD, valid: 1'b0};

  // Redirect targets are word addresses; low byte-offset bits are dropped.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr_i is a
// synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (clr_i)                        count_q <= '0;
    else if (inc_i && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign count_o = count_q;
endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, redirect/stall next-PC mux,
// IF/ID pipeline register, IDLE/RUN control and stall/flush event counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                jump_i,
  input  logic [DATA_W-1:0]   jump_target_i,
  input  logic                branch_taken_i,
  input  logic [DATA_W-1:0]   branch_target_i,
  output logic [DATA_W-1:0]   imem_addr_o,
  input  logic [INSTR_W-1:0]  imem_data_i,
  output logic [DATA_W-1:0]   pc_o,
  output logic [DATA_W-1:0]   if_id_pc4_o,
  output logic [INSTR_W-1:0]  if_id_instr_o,
  output logic                if_id_valid_o,
  output logic [CNT_W-1:0]    stall_count_o,
  output logic [CNT_W-1:0]    flush_count_o
);
  // Sequential fetch wraps inside the instruction memory (power-of-two depth).
  localparam logic [DATA_W-1:0] PC_MASK = DATA_W'(4 * IMEM_DEPTH - 1);

  state_e            state_q;
  logic [DATA_W-1:0] pc_q, pc_d, pc_seq;
  if_id_t            if_id_q, if_id_d;
  logic              active, stall_ev, flush_ev;

  assign active = (state_q == ST_RUN) && start_i;
  assign pc_seq = (pc_q + PC_INC) & PC_MASK;

  always_comb begin
    pc_d     = pc_q;
    if_id_d  = if_id_q;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    if (active) begin
      if (jump_i) begin
        pc_d     = word_align(jump_target_i);
        if_id_d  = IF_ID_BUBBLE;
        flush_ev = 1'b1;
      end else if (branch_taken_i) begin
        pc_d     = word_align(branch_target_i);
        if_id_d  = IF_ID_BUBBLE;
        flush_ev = 1'b1;
      end else if (stall_i) begin
        stall_ev = 1'b1;
      end else begin
        pc_d    = pc_seq;
        if_id_d = '{pc4: pc_seq, instr: imem_data_i, valid: 1'b1};
      end
    end
  end

  // Leaving RUN only freezes the stage; the IF/ID contents stay as they were.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i)  state_q <= ST_RUN;
        ST_RUN:  if (!start_i) state_q <= ST_IDLE;
        default:               state_q <= ST_IDLE;
      endcase
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (stall_ev),
    .count_o (stall_count_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .inc_i   (flush_ev),
    .count_o (flush_count_o)
  );

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign if_id_pc4_o   = if_id_q.pc4;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, hand-written corner sequences,
// then randomized cycles against a behavioural model of the fetch rules.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_i, start_i, stall_i, jump_i, branch_taken_i;
  logic [31:0] jump_target_i, branch_target_i;
  logic [31:0] imem_addr_o, imem_data_i, pc_o, if_id_pc4_o, if_id_instr_o;
  logic        if_id_valid_o;
  logic [15:0] stall_count_o, flush_count_o;
  // Second instance with 2-bit counters to exercise saturation
  logic [31:0] s_imem_addr_o, s_pc_o, s_pc4_o, s_instr_o;
  logic        s_valid_o;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [31:0] mem [256];
  assign imem_data_i = mem[imem_addr_o[9:2]];

  always #5 clk = ~clk;

  if_stage #(.IMEM_DEPTH(256), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i), .pc_o(pc_o),
    .if_id_pc4_o(if_id_pc4_o), .if_id_instr_o(if_id_instr_o),
    .if_id_valid_o(if_id_valid_o), .stall_count_o(stall_count_o),
    .flush_count_o(flush_count_o));

  if_stage #(.IMEM_DEPTH(256), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_addr_o(s_imem_addr_o), .imem_data_i(imem_data_i), .pc_o(s_pc_o),
    .if_id_pc4_o(s_pc4_o), .if_id_instr_o(s_instr_o),
    .if_id_valid_o(s_valid_o), .stall_count_o(s_stall_cnt),
    .flush_count_o(s_flush_cnt));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt);
    start_i = st; stall_i = sl; jump_i = j; jump_target_i = jt;
    branch_taken_i = b; branch_target_i = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic e_valid, input logic [31:0] e_pc4,
                         input int e_st, input int e_fl);
    chk({tag, ".pc"},    pc_o, e_pc);
    chk({tag, ".addr"},  imem_addr_o, e_pc);
    chk({tag, ".instr"}, if_id_instr_o, e_instr);
    chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, e_valid});
    if (e_valid) chk({tag, ".pc4"}, if_id_pc4_o, e_pc4);
    chk({tag, ".stall"}, {16'd0, stall_count_o}, 32'(e_st));
    chk({tag, ".flush"}, {16'd0, flush_count_o}, 32'(e_fl));
  endtask

  typedef struct {
    string       name;
    logic        start, stall, jump, br;
    logic [31:0] jt, bt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    int          e_st, e_fl;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input string n, input logic st, input logic sl, input logic j,
                              input logic [31:0] jt, input logic b, input logic [31:0] bt,
                              input logic [31:0] pc, input logic [31:0] ins, input logic v,
                              input logic [31:0] p4, input int s, input int f);
    vec_t r;
    r.name = n; r.start = st; r.stall = sl; r.jump = j; r.jt = jt; r.br = b; r.bt = bt;
    r.e_pc = pc; r.e_instr = ins; r.e_valid = v; r.e_pc4 = p4; r.e_st = s; r.e_fl = f;
    return r;
  endfunction

  // Reference model state
  logic        m_run;
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid;
  int          m_st, m_fl;

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_st = 0; m_fl = 0;
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = mem[(m_pc / 4) % 256];
    if (rst_i) model_reset();
    else if (!m_run) m_run = start_i;
    else if (!start_i) m_run = 0;
    else if (jump_i || branch_taken_i) begin
      m_pc = (jump_i ? jump_target_i : branch_target_i) & ~32'd3;
      m_instr = 0; m_valid = 0; m_pc4 = 0;
      if (m_fl < 65535) m_fl++;
    end else if (stall_i) begin
      if (m_st < 65535) m_st++;
    end else begin
      m_pc = (m_pc + 4) % 1024;
      m_pc4 = m_pc; m_instr = word; m_valid = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[32] = 32'hAA; mem[255] = 32'hFF;

    //            name    st sl j  jt        b  bt        pc      instr v  pc4    st fl
    tbl[0]  = mk("go",    1, 0, 0, 0,        0, 0,        0,      0,    0, 0,     0, 0);
    tbl[1]  = mk("seq1",  1, 0, 0, 0,        0, 0,        4,      'h11, 1, 4,     0, 0);
    tbl[2]  = mk("seq2",  1, 0, 0, 0,        0, 0,        8,      'h22, 1, 8,     0, 0);
    tbl[3]  = mk("stl1",  1, 1, 0, 0,        0, 0,        8,      'h22, 1, 8,     1, 0);
    tbl[4]  = mk("stl2",  1, 1, 0, 0,        0, 0,        8,      'h22, 1, 8,     2, 0);
    tbl[5]  = mk("brstl", 1, 1, 0, 0,        1, 'h40,     'h40,   0,    0, 0,     2, 1);
    tbl[6]  = mk("jpbr",  1, 0, 1, 'h80,     1, 'h40,     'h80,   0,    0, 0,     2, 2);
    tbl[7]  = mk("jpmis", 1, 0, 1, 'h83,     0, 0,        'h80,   0,    0, 0,     2, 3);
    tbl[8]  = mk("seq3",  1, 0, 0, 0,        0, 0,        'h84,   'hAA, 1, 'h84,  2, 3);
    tbl[9]  = mk("jptop", 1, 0, 1, 'h3FC,    0, 0,        'h3FC,  0,    0, 0,     2, 4);
    tbl[10] = mk("wrap",  1, 0, 0, 0,        0, 0,        0,      'hFF, 1, 0,     2, 4);
    tbl[11] = mk("idle1", 0, 1, 1, 'h100,    0, 0,        0,      'hFF, 1, 0,     2, 4);
    tbl[12] = mk("idle2", 0, 0, 0, 0,        1, 'h200,    0,      'hFF, 1, 0,     2, 4);

    // Reset held 3 cycles, then idle with start low
    rst_i = 1; drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk_all("rst", 0, 0, 0, 0, 0, 0);
    rst_i = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk_all("idle", 0, 0, 0, 0, 0, 0);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stall, tbl[i].jump, tbl[i].jt, tbl[i].br, tbl[i].bt);
      tick();
      chk_all(tbl[i].name, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_valid, tbl[i].e_pc4,
              tbl[i].e_st, tbl[i].e_fl);
    end

    // Saturation: 2-bit stall counter already at 2, five more stalls
    drive(1, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    chk("sat.stall16", {16'd0, stall_count_o}, 32'd7);
    chk("sat.stall2", {30'd0, s_stall_cnt}, 32'd3);
    chk("sat.flush2", {30'd0, s_flush_cnt}, 32'd3);
    chk("sat.pc2", s_pc_o, 32'd0);

    // Reset mid-run wins over a jump
    rst_i = 1; drive(1, 0, 1, 'h40, 0, 0); tick();
    chk_all("midrst", 0, 0, 0, 0, 0, 0);
    chk("midrst.stall2", {30'd0, s_stall_cnt}, 32'd0);
    chk("midrst.valid2", {31'd0, s_valid_o}, 32'd0);
    rst_i = 0;

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0,
            ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 1023)) : $urandom,
            $urandom_range(0, 7) == 0, 32'($urandom_range(0, 1023)));
      model_step();
      tick();
      chk_all("rnd", m_pc, m_instr, m_valid, m_pc4, m_st, m_fl);
      chk("rnd.stall2", {30'd0, s_stall_cnt}, 32'((m_st > 3) ? 3 : m_st));
      chk("rnd.flush2", {30'd0, s_flush_cnt}, 32'((m_fl > 3) ? 3 : m_fl));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
